// File: rtl/mod_updown_counter_pkg.sv
// Shared counter definitions: direction encodings and a ceiling-log2 helper
// used to size prescaler registers. Intended for reuse by timer blocks.
// No ports.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Bits needed to hold 0..v-1; never less than 1 so a register always exists.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter.
//  en, up_dn, load, load_val : driven by the master (count control)
//  q, tc, wrap               : driven by the counter (slave)
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  q, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output q, tc, wrap
  );
endinterface

// File: rtl/mod_updown_counter_prescaler.sv
// clk_en_prescaler: divides qualified enable cycles by PRESCALE.
//  clk, reset (async, active-high), en (qualifier), clr (sync clear)
//  tick : high on the en cycle that completes a PRESCALE-long phase
// The phase counter holds while en is low, so an interrupted phase resumes.
module clk_en_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  assign tick = en && (pcnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
    end
  end
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: synchronous modulo-MODULUS up/down counter with
// parallel load, enable prescaler, terminal-count and wrap flags.
//  clk   : rising-edge clock
//  reset : asynchronous, active-high
//  bus   : mod_updown_counter_if.slave (en, up_dn, load, load_val -> q, tc, wrap)
// Build option COUNTER_SATURATE_EN: hold at the bound instead of wrapping;
// wrap then never asserts.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input logic                 clk,
  input logic                 reset,
  mod_updown_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_r;
  logic             wrap_nxt;
  logic             tick;
  logic             at_max;
  logic             at_min;

  generate
    if (PRESCALE > 1) begin : g_pre
      clk_en_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .clr   (bus.load),
        .tick  (tick)
      );
    end else begin : g_nopre
      assign tick = bus.en;
    end
  endgenerate

  assign at_max = (q_r == MAX_Q);
  assign at_min = (q_r == '0);

  always_comb begin
    q_nxt    = q_r;
    wrap_nxt = 1'b0;
    if (bus.load) begin
      // Out-of-range load values clamp to the top of the count range.
      q_nxt = (32'(bus.load_val) >= MODULUS) ? MAX_Q : bus.load_val;
    end else if (tick) begin
      if (bus.up_dn == DIR_UP) begin
        if (at_max) begin
`ifdef COUNTER_SATURATE_EN
          q_nxt = q_r;
`else
          q_nxt    = '0;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = q_r + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
`ifdef COUNTER_SATURATE_EN
          q_nxt = q_r;
`else
          q_nxt    = MAX_Q;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = q_r - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  assign bus.q    = q_r;
  assign bus.wrap = wrap_r;
  assign bus.tc   = (bus.up_dn == DIR_UP) ? at_max : at_min;
endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;
  localparam int W = 4;
  localparam int M = 10;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;

  int n_checks = 0;
  int n_errors = 0;

  // reference state: index 0 -> PRESCALE=1 instance, index 1 -> PRESCALE=3
  int mq[2];
  int mp[2];
  int mw[2];
  int presc[2] = '{1, 3};

  mod_updown_counter_if #(.WIDTH(W)) bus1 ();
  mod_updown_counter_if #(.WIDTH(W)) bus3 ();

  assign bus1.en = en;
  assign bus1.up_dn = up_dn;
  assign bus1.load = load;
  assign bus1.load_val = load_val;
  assign bus3.en = en;
  assign bus3.up_dn = up_dn;
  assign bus3.load = load;
  assign bus3.load_val = load_val;

  mod_updown_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  mod_updown_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: one rising edge with the currently applied inputs.
  task automatic model_step(input int i);
    int tk;
    if (reset) begin
      mq[i] = 0; mp[i] = 0; mw[i] = 0;
    end else if (load) begin
      mq[i] = (int'(load_val) >= M) ? M - 1 : int'(load_val);
      mp[i] = 0; mw[i] = 0;
    end else begin
      tk = 0;
      mw[i] = 0;
      if (en) begin
        mp[i] = mp[i] + 1;
        if (mp[i] == presc[i]) begin
          tk = 1;
          mp[i] = 0;
        end
      end
      if (tk == 1) begin
        if (up_dn) begin
          if (mq[i] == M - 1) begin
`ifndef COUNTER_SATURATE_EN
            mq[i] = 0; mw[i] = 1;
`endif
          end else mq[i] = mq[i] + 1;
        end else begin
          if (mq[i] == 0) begin
`ifndef COUNTER_SATURATE_EN
            mq[i] = M - 1; mw[i] = 1;
`endif
          end else mq[i] = mq[i] - 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int tc_exp[2];
    for (int i = 0; i < 2; i++)
      tc_exp[i] = up_dn ? int'(mq[i] == M - 1) : int'(mq[i] == 0);
    check({tag, ".q1"},    int'(bus1.q),    mq[0]);
    check({tag, ".wrap1"}, int'(bus1.wrap), mw[0]);
    check({tag, ".tc1"},   int'(bus1.tc),   tc_exp[0]);
    check({tag, ".q3"},    int'(bus3.q),    mq[1]);
    check({tag, ".wrap3"}, int'(bus3.wrap), mw[1]);
    check({tag, ".tc3"},   int'(bus3.tc),   tc_exp[1]);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic e, input logic u, input logic l, input logic [3:0] lv);
    en = e; up_dn = u; load = l; load_val = lv;
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    mq = '{0, 0}; mp = '{0, 0}; mw = '{0, 0};
    check({tag, ".q1"},    int'(bus1.q), 0);
    check({tag, ".wrap1"}, int'(bus1.wrap), 0);
    check({tag, ".q3"},    int'(bus3.q), 0);
    cycle(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    mq = '{0, 0}; mp = '{0, 0}; mw = '{0, 0};
    repeat (2) cycle("reset");
    reset = 1'b0;

    // count to 7 (and part way through a prescale phase), then reset
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    repeat (7) cycle("pre7");
    check("at7", int'(bus1.q), 7);
    async_reset("rst_mid");

    drive(1'b1, 1'b1, 1'b0, 4'd0);
    repeat (12) cycle("up12");

    drive(1'b0, 1'b0, 1'b1, 4'd1);
    cycle("ld1");
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    repeat (3) cycle("down");

    drive(1'b1, 1'b1, 1'b1, 4'd13);
    cycle("ld13");
    check("clamp", int'(bus1.q), 9);
    check("clamp_wrap", int'(bus1.wrap), 0);
    drive(1'b1, 1'b1, 1'b1, 4'd3);
    cycle("ld_vs_tick");
    check("ld_wins", int'(bus1.q), 3);
    check("ld_wins_wrap", int'(bus1.wrap), 0);

    async_reset("rst2");
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    repeat (4) cycle("psc_a");
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    repeat (2) cycle("psc_hold");
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    repeat (5) cycle("psc_b");
    check("psc_q3", int'(bus3.q), 3);

    drive(1'b0, 1'b1, 1'b1, 4'd8);
    cycle("ld8");
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    repeat (4) cycle("sat_up");
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    cycle("sat_dn");

    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
      cycle("rand");
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
